// File: rtl/alu_pipe_pkg.sv
// Shared op encoding for the alu_pipe block (optional accumulator under ALU_PIPE_ACC_EN).
package alu_pipe_pkg;

    localparam int unsigned OpWidth = 3;

    typedef enum logic [OpWidth-1:0] {
        OpSub   = 3'b000,
        OpAddBc = 3'b001,
        OpOr    = 3'b010,
        OpXor   = 3'b011,
        OpAnd   = 3'b100,
        OpAdd3  = 3'b101,
        OpAcc   = 3'b110,
        OpRdClr = 3'b111
    } op_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath for alu_pipe stage 2; accumulator ports exist only
// when ALU_PIPE_ACC_EN is defined.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  op_e              op,
`ifdef ALU_PIPE_ACC_EN
    input  logic [WIDTH-1:0] acc,
    output logic             acc_we,
    output logic [WIDTH-1:0] acc_next,
`endif
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    logic [WIDTH:0]   sum2;
    logic [WIDTH+1:0] sum3;

    always_comb begin
        r     = '0;
        carry = 1'b0;
        err   = 1'b0;
        sum2  = '0;
        sum3  = '0;
`ifdef ALU_PIPE_ACC_EN
        acc_we   = 1'b0;
        acc_next = acc;
`endif
        case (op)
            OpSub: begin
                r     = a - b;
                carry = (a < b);
            end
            OpAddBc: begin
                sum2  = {1'b0, b} + {1'b0, c};
                r     = sum2[WIDTH-1:0];
                carry = sum2[WIDTH];
            end
            OpOr:  r = b | c;
            OpXor: r = a ^ c;
            OpAnd: r = a & b;
            OpAdd3: begin
                sum3  = {2'b00, a} + {2'b00, b} + {2'b00, c};
                r     = sum3[WIDTH-1:0];
                carry = |sum3[WIDTH+1:WIDTH];
            end
`ifdef ALU_PIPE_ACC_EN
            OpAcc: begin
                sum2     = {1'b0, acc} + {1'b0, a};
                r        = sum2[WIDTH-1:0];
                carry    = sum2[WIDTH];
                acc_we   = 1'b1;
                acc_next = sum2[WIDTH-1:0];
            end
            OpRdClr: begin
                r        = acc;
                acc_we   = 1'b1;
                acc_next = '0;
            end
`else
            // Accumulator ops are illegal in this build: flag them, result forced to 0.
            OpAcc, OpRdClr: err = 1'b1;
`endif
            default: r = '0;
        endcase
        zero = (r == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline; define ALU_PIPE_ACC_EN to build the
// accumulator and ops 110/111.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    op_e              op_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] r_q;
    logic             carry_q, zero_q, err_q;

    logic             accept;
    logic             s1_adv;

    logic [WIDTH-1:0] core_r;
    logic             core_carry, core_zero, core_err;

    // S1 drains into S2 whenever S2 is empty or being emptied this cycle.
    assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            op_q       <= OpSub;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            a_q        <= a;
            b_q        <= b;
            c_q        <= c;
            op_q       <= op_e'(op);
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

`ifdef ALU_PIPE_ACC_EN
    logic [WIDTH-1:0] acc_q;
    logic             acc_we;
    logic [WIDTH-1:0] acc_next;

    // Accumulator commits only as its op enters S2, so stalls never touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (s1_adv && acc_we) begin
            acc_q <= acc_next;
        end
    end
`endif

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (a_q),
        .b        (b_q),
        .c        (c_q),
        .op       (op_q),
`ifdef ALU_PIPE_ACC_EN
        .acc      (acc_q),
        .acc_we   (acc_we),
        .acc_next (acc_next),
`endif
        .r        (core_r),
        .carry    (core_carry),
        .zero     (core_zero),
        .err      (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            r_q        <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= 1'b1;
            r_q        <= core_r;
            carry_q    <= core_carry;
            zero_q     <= core_zero;
            err_q      <= core_err;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign r         = r_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8); accumulator tests run
// only when ALU_PIPE_ACC_EN is defined, otherwise the disabled-op behaviour is checked.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] r;
    logic         carry, zero, err;

    int checks = 0;
    int errors = 0;

    alu_pipe #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Issue one op with out_ready=1; res = {r, carry, zero, err}, lat = cycles to out_valid.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ic, output logic [W+2:0] res, output int lat);
        out_ready = 1'b1;
        op = o; a = ia; b = ib; c = ic;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = {r, carry, zero, err};
    endtask

    task automatic test_reset();
        checks++;
        if ({out_valid, in_ready, r, carry, zero, err} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_state got ov=%b ir=%b r=%h c=%b z=%b e=%b want 0 1 00 0 0 0",
                     out_valid, in_ready, r, carry, zero, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL after_reset got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [2:0]   ops [8];
        logic [W-1:0] va [8], vb [8], vc [8];
        logic [W+2:0] exp [8];
        logic [W+2:0] res;
        int           lat;
        ops[0] = 3'b000; va[0] = 8'h03; vb[0] = 8'h05; vc[0] = 8'h00; exp[0] = {8'hFE, 3'b100};
        ops[1] = 3'b101; va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 8'hFF; exp[1] = {8'hFD, 3'b100};
        ops[2] = 3'b011; va[2] = 8'h5A; vb[2] = 8'h77; vc[2] = 8'h5A; exp[2] = {8'h00, 3'b010};
        ops[3] = 3'b001; va[3] = 8'h00; vb[3] = 8'hF0; vc[3] = 8'h20; exp[3] = {8'h10, 3'b100};
        ops[4] = 3'b010; va[4] = 8'hFF; vb[4] = 8'h0F; vc[4] = 8'h30; exp[4] = {8'h3F, 3'b000};
        ops[5] = 3'b100; va[5] = 8'hCC; vb[5] = 8'hAA; vc[5] = 8'hFF; exp[5] = {8'h88, 3'b000};
        ops[6] = 3'b000; va[6] = 8'h05; vb[6] = 8'h03; vc[6] = 8'h00; exp[6] = {8'h02, 3'b000};
        ops[7] = 3'b101; va[7] = 8'h01; vb[7] = 8'h02; vc[7] = 8'h03; exp[7] = {8'h06, 3'b000};
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], va[i], vb[i], vc[i], res, lat);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL basic_%0d op=%b got {r,c,z,e}=%h want %h", i, ops[i], res, exp[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL basic_lat_%0d got %0d want 2", i, lat);
            end
        end
    endtask

`ifdef ALU_PIPE_ACC_EN
    task automatic test_back_to_back_acc();
        logic [2:0]   ops [3];
        logic [W-1:0] va [3];
        logic [W:0]   exp [3];
        logic [W+2:0] res;
        int           lat;
        ops[0] = 3'b110; va[0] = 8'h80; exp[0] = {8'h80, 1'b0};
        ops[1] = 3'b110; va[1] = 8'h81; exp[1] = {8'h01, 1'b1};
        ops[2] = 3'b111; va[2] = 8'h00; exp[2] = {8'h01, 1'b0};
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n >= 2) begin
                checks++;
                if ({out_valid, r, carry} !== {1'b1, exp[n-2]}) begin
                    errors++;
                    $display("FAIL acc_b2b_%0d got ov=%b r=%h c=%b want ov=1 {r,c}=%h",
                             n - 2, out_valid, r, carry, exp[n-2]);
                end
            end
            if (n < 3) begin
                op = ops[n]; a = va[n]; b = 8'h00; c = 8'h00; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        run_op(3'b111, 8'h00, 8'h00, 8'h00, res, lat);
        checks++;
        if (res !== {8'h00, 3'b010}) begin
            errors++;
            $display("FAIL acc_cleared got {r,c,z,e}=%h want 002", res);
        end
    endtask
`else
    task automatic test_no_acc();
        logic [W+2:0] res;
        int           lat;
        run_op(3'b110, 8'h55, 8'h11, 8'h22, res, lat);
        checks++;
        if (res !== {8'h00, 3'b011}) begin
            errors++;
            $display("FAIL noacc_110 got {r,c,z,e}=%h want 003", res);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL noacc_lat got %0d want 2", lat);
        end
        run_op(3'b111, 8'hAA, 8'h00, 8'h00, res, lat);
        checks++;
        if (res !== {8'h00, 3'b011}) begin
            errors++;
            $display("FAIL noacc_111 got {r,c,z,e}=%h want 003", res);
        end
    endtask
`endif

    task automatic test_stall();
        int           accepts = 0;
        int           got = 0;
        logic [W-1:0] seen [4];
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                checks++;
                if ({out_valid, r} !== {1'b1, 8'h11}) begin
                    errors++;
                    $display("FAIL stall_hold_%0d got ov=%b r=%h want ov=1 r=11", i, out_valid, r);
                end
            end
            op = 3'b010; a = 8'h00; b = 8'h01 + 8'(accepts); c = 8'h10; in_valid = 1'b1;
            if (in_ready) accepts++;
            if (i < 4) @(negedge clk);
        end
        checks++;
        if (accepts !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accepts got %0d ir=%b want 2 ir=0", accepts, in_ready);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (out_valid && got < 4) begin
                seen[got] = r;
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got !== 2) begin
            errors++;
            $display("FAIL stall_count got %0d want 2", got);
        end else begin
            checks++;
            if ({seen[0], seen[1]} !== 16'h1112) begin
                errors++;
                $display("FAIL stall_order got %h %h want 11 12", seen[0], seen[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W+2:0] res;
        int           lat;
        int           stale = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        op = 3'b100; a = 8'hF0; b = 8'hFF; c = 8'h00; in_valid = 1'b1;
        @(negedge clk);
        op = 3'b010; b = 8'h01; c = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_full got ov=%b ir=%b want ov=1 ir=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, r} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL rstmid_async got ov=%b ir=%b r=%h want 0 1 00", out_valid, in_ready, r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL rstmid_stale got %0d stale results want 0", stale);
        end
        run_op(3'b000, 8'h10, 8'h01, 8'h00, res, lat);
        checks++;
        if (res !== {8'h0F, 3'b000} || lat !== 2) begin
            errors++;
            $display("FAIL rstmid_after got {r,c,z,e}=%h lat=%0d want 078 lat=2", res, lat);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
`ifdef ALU_PIPE_ACC_EN
        test_back_to_back_acc();
`else
        test_no_acc();
`endif
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish want finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state rises on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, reset. Reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set presented.
REQ-005 SHALL have port in_ready, output, 1, block accepts the operand set this cycle.
REQ-006 SHALL have ports a, b, c, input, WIDTH each, operands.
REQ-007 SHALL have port op, input, 3, operation code.
REQ-008 SHALL have port out_valid, output, 1, result held on r/flags.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have port r, output, WIDTH, result.
REQ-011 SHALL have ports carry, zero, err, output, 1 each, result flags.

Function
REQ-012 SHALL decode op as follows: 000 a-b; 001 b+c; 010 b|c; 011 a^c; 100 a&b; 101 a+b+c; 110 acc+a (accumulate); 111 read-and-clear acc.
REQ-013 SHALL truncate r modulo 2^WIDTH for all ops.
REQ-014 SHALL set carry to the borrow (a<b unsigned) for 000, to bit WIDTH of the sum for 001/110, to the OR of the bits above WIDTH-1 for 101, and to 0 for the logic ops and 111.
REQ-015 SHALL set zero to 1 when r equals 0; err to 1 only per REQ-025.
REQ-016 SHALL be a two-stage pipeline: S1 registers a/b/c/op on accept; S2 computes and registers r/flags.
REQ-017 SHALL accept an operand set on a cycle where in_valid and in_ready are both 1; result appears with out_valid=1 exactly 2 cycles after accept when out_ready is held at 1.
REQ-018 SHALL advance S1->S2 when S1 is valid and (S2 empty or out_ready=1); in_ready = !S1_valid or S1 advancing (combinational).
REQ-019 SHALL hold r/flags/out_valid stable while out_valid=1 and out_ready=0; no data loss or duplication under any in_valid/out_ready pattern.
REQ-020 SHALL sustain one result per cycle with in_valid=out_ready=1 continuously.
REQ-021 SHALL update acc only when an op 110/111 moves into S2: 110 sets acc to acc+a (wrap), r = new acc; 111 sets r = old acc, acc to 0.
REQ-022 SHALL chain back-to-back accumulate ops so that each sees the acc written by its predecessor; stalls SHALL NOT update acc.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear S1/S2 valids, acc, r, carry, zero, err to 0; out_valid=0; in_ready=1 one cycle after rst_n deasserts. In-flight operations SHALL be discarded on reset mid-operation.

Configuration
REQ-024 SHALL implement acc and ops 110/111 only when macro ALU_PIPE_ACC_EN is defined.
REQ-025 SHALL, without ALU_PIPE_ACC_EN, contain no acc register; ops 110/111 produce r=0, carry=0, zero=1, err=1 with normal pipeline timing.

Structure
REQ-026 SHALL place the op encoding constants and the op typedef in shared package alu_pipe_pkg.
REQ-027 SHALL implement the combinational datapath of REQ-012..REQ-015 in one sub-module alu_pipe_core, instantiated in S2.

Verification
REQ-028 SHALL cover, WIDTH=8, out_ready=1: op=000 a=3 b=5 -> r=0xFE, carry=1, zero=0, out_valid 2 cycles after accept.
REQ-029 SHALL cover op=101 a=b=c=0xFF -> r=0xFD, carry=1; op=011 a=c=0x5A -> r=0, zero=1.
REQ-030 SHALL cover back-to-back ops 110 a=0x80, 110 a=0x81, 111 -> r=0x80, 0x01 (carry=1), 0x01; then acc=0.
REQ-031 SHALL cover out_ready=0 for 5 cycles with in_valid=1: in_ready drops after 2 accepts, r stable, all results later delivered in order.
REQ-032 SHALL cover rst_n pulsed low with both stages full -> out_valid=0 immediately, no stale result after reset.
REQ-033 SHALL cover build without ALU_PIPE_ACC_EN: op=110 -> r=0, err=1, zero=1.
